fetch_redirect_ctrl: RTL and testbench

- Sequences the IF stage PC mux and PC write enable for the 5-stage MIPS pipeline.
- Arbitrates redirect requests by instruction age: trap (EX), taken branch (EX), jr (ID), j (ID).
- Merges those requests with the load-use stall and a global freeze, and generates the pipeline flush/bubble controls.
- Runs a small FSM for trap entry: drain, then vector to the trap handler. Captures the EPC.

---
 rtl/pipe_ctrl_pkg.sv | 30 +++
 rtl/redirect_prio_enc.sv | 16 +
 rtl/fetch_redirect_ctrl.sv | 125 ++++++++++++
 tb/tb_fetch_redirect_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared encodings and constants for the IF redirect control slice
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      VECTOR = 2'd2
   } state_t;

   // Redirect sources, oldest instruction first; five codes need three bits
   typedef enum logic [2:0] {
      PEND_NONE = 3'd0,
      PEND_TRAP = 3'd1,
      PEND_BR   = 3'd2,
      PEND_JR   = 3'd3,
      PEND_J    = 3'd4
   } pend_t;

   // Trap handler entry address; IF owns the actual mux constant
   localparam logic [31:0] TRAP_VECTOR = 32'h00000064;

   // Request-vector form {trap, br, jr, j} of a pending code
   function automatic logic [3:0] pend_onehot(input pend_t p);
      return p == PEND_TRAP ? 4'b1000 :
             p == PEND_BR   ? 4'b0100 :
             p == PEND_JR   ? 4'b0010 :
             p == PEND_J    ? 4'b0001 : 4'b0000;
   endfunction

endpackage

// File: rtl/redirect_prio_enc.sv
// redirect_prio_enc: age-priority encoder of {trap, br, jr, j} to one-hot grant and pending code
module redirect_prio_enc
   import pipe_ctrl_pkg::*;
(
   input  logic [3:0] req,
   output logic [3:0] grant,
   output pend_t      code
);

   // Oldest instruction wins: trap (EX) > branch (EX) > jr (ID) > j (ID)
   always_comb begin
      grant = req[3] ? 4'b1000 : req[2] ? 4'b0100 : req[1] ? 4'b0010 : req[0] ? 4'b0001 : 4'b0000;
      code  = req[3] ? PEND_TRAP : req[2] ? PEND_BR : req[1] ? PEND_JR : req[0] ? PEND_J : PEND_NONE;
   end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl: IF PC-mux / PC-write sequencing, redirect arbitration and trap entry
module fetch_redirect_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int DRAIN_CYCLES = 2,
   parameter int CNT_W        = 4
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        trap_req,
   input  logic        br_taken,
   input  logic        jr_req,
   input  logic        j_req,
   input  logic        load_use_stall,
   input  logic        freeze,
   input  logic [31:0] pc_ex,
   output logic        sel_trap,
   output logic        sel_jr,
   output logic        sel_j,
   output logic        sel_z,
   output logic        pc_write,
   output logic        if_id_write,
   output logic        flush_if_id,
   output logic        flush_id_ex,
   output logic [31:0] epc,
   output logic        trap_busy
);

   state_t           state, state_n;
   pend_t            pend, pend_n, code;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [31:0]      epc_n;
   logic [3:0]       grant;
   logic             id_blocked;

   // A pending request merges with live ones; the older source still wins
   redirect_prio_enc u_enc (
      .req   ({trap_req, br_taken, jr_req, j_req} | pend_onehot(pend)),
      .grant (grant),
      .code  (code)
   );

   // jr/j cannot redirect while their own instruction is stalled in ID
   assign id_blocked = (grant[1] | grant[0]) & load_use_stall;

   // State, drain counter, pending redirect and EPC registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= RUN;
         cnt   <= '0;
         pend  <= PEND_NONE;
         epc   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         pend  <= pend_n;
         epc   <= epc_n;
      end
   end

   // Next state: freeze holds everything but pending capture; traps are only accepted in RUN
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      pend_n  = pend;
      epc_n   = (state == RUN && trap_req) ? pc_ex : epc;
      if (freeze) begin
         if (state == RUN)
            pend_n = code;
      end else begin
         case (state)
            RUN: begin
               pend_n = id_blocked ? pend : PEND_NONE;
               if (grant[3]) begin
                  cnt_n   = CNT_W'(DRAIN_CYCLES - 1);
                  state_n = (DRAIN_CYCLES == 1) ? VECTOR : DRAIN;
               end
            end
            DRAIN: begin
               cnt_n   = cnt - CNT_W'(1);
               state_n = (cnt == CNT_W'(1)) ? VECTOR : DRAIN;
            end
            VECTOR:  state_n = RUN;
            default: state_n = RUN;
         endcase
      end
   end

   // Outputs: selects come only from the one-hot grant, so at most one is ever set
   always_comb begin
      sel_trap    = 1'b0;
      sel_jr      = 1'b0;
      sel_j       = 1'b0;
      sel_z       = 1'b0;
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      flush_if_id = 1'b0;
      flush_id_ex = 1'b0;
      trap_busy   = (state == DRAIN) || (state == VECTOR);
      if (freeze) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
      end else if (state == DRAIN || state == VECTOR) begin
         sel_trap    = (state == VECTOR);
         pc_write    = (state == VECTOR);
         flush_if_id = 1'b1;
         flush_id_ex = 1'b1;
      end else if (grant[3] || grant[2]) begin
         sel_z       = grant[2];
         pc_write    = grant[2];
         flush_if_id = 1'b1;
         flush_id_ex = 1'b1;
      end else if (load_use_stall) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         flush_id_ex = 1'b1;
      end else begin
         sel_jr      = grant[1];
         sel_j       = grant[0];
         flush_if_id = grant[1] | grant[0];
      end
   end

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// tb_fetch_redirect_ctrl: directed vectors for the IF redirect controller with a small IF PC model
module tb_fetch_redirect_ctrl;
   import pipe_ctrl_pkg::*;

   localparam logic [31:0] Z_T  = 32'h00000100;
   localparam logic [31:0] JR_T = 32'h00000200;
   localparam logic [31:0] J_T  = 32'h00000300;

   // Output vector {sel_trap, sel_jr, sel_j, sel_z, pc_write, if_id_write, flush_if_id, flush_id_ex, trap_busy}
   localparam logic [8:0] O_IDLE  = 9'b0000_1_1_0_0_0;
   localparam logic [8:0] O_BR    = 9'b0001_1_1_1_1_0;
   localparam logic [8:0] O_JR    = 9'b0100_1_1_1_0_0;
   localparam logic [8:0] O_J     = 9'b0010_1_1_1_0_0;
   localparam logic [8:0] O_STALL = 9'b0000_0_0_0_1_0;
   localparam logic [8:0] O_TACC  = 9'b0000_0_1_1_1_0;
   localparam logic [8:0] O_DRN   = 9'b0000_0_1_1_1_1;
   localparam logic [8:0] O_VEC   = 9'b1000_1_1_1_1_1;
   localparam logic [8:0] O_FRZ   = 9'b0000_0_0_0_0_0;
   localparam logic [8:0] O_FRZB  = 9'b0000_0_0_0_0_1;

   // Input vector {trap_req, br_taken, jr_req, j_req, load_use_stall, freeze}
   localparam logic [5:0] I_NONE  = 6'b000000;
   localparam logic [5:0] I_TRAP  = 6'b100000;
   localparam logic [5:0] I_BRJ   = 6'b010100;
   localparam logic [5:0] I_JRLU  = 6'b001010;
   localparam logic [5:0] I_JR    = 6'b001000;
   localparam logic [5:0] I_J     = 6'b000100;
   localparam logic [5:0] I_LU    = 6'b000010;
   localparam logic [5:0] I_FRZ   = 6'b000001;
   localparam logic [5:0] I_FRZBR = 6'b010001;
   localparam logic [5:0] I_FRZJ  = 6'b000101;
   localparam logic [5:0] I_BR    = 6'b010000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        trap_req, br_taken, jr_req, j_req, load_use_stall, freeze;
   logic [31:0] pc_ex = '0;
   logic        sel_trap, sel_jr, sel_j, sel_z, pc_write, if_id_write, flush_if_id, flush_id_ex, trap_busy;
   logic [31:0] epc;
   logic [31:0] pc;
   logic [8:0]  outs;
   int          n_tests = 0;
   int          n_fail = 0;

   fetch_redirect_ctrl #(.DRAIN_CYCLES(2), .CNT_W(4)) dut (
      .clk            (clk),
      .reset          (reset),
      .trap_req       (trap_req),
      .br_taken       (br_taken),
      .jr_req         (jr_req),
      .j_req          (j_req),
      .load_use_stall (load_use_stall),
      .freeze         (freeze),
      .pc_ex          (pc_ex),
      .sel_trap       (sel_trap),
      .sel_jr         (sel_jr),
      .sel_j          (sel_j),
      .sel_z          (sel_z),
      .pc_write       (pc_write),
      .if_id_write    (if_id_write),
      .flush_if_id    (flush_if_id),
      .flush_id_ex    (flush_id_ex),
      .epc            (epc),
      .trap_busy      (trap_busy)
   );

   always #5 clk = ~clk;

   assign outs = {sel_trap, sel_jr, sel_j, sel_z, pc_write, if_id_write, flush_if_id, flush_id_ex, trap_busy};

   // IF program counter as the real IF stage would build it from the mux selects
   always @(posedge clk or posedge reset) begin
      if (reset)
         pc <= '0;
      else if (pc_write)
         pc <= sel_trap ? TRAP_VECTOR : sel_jr ? JR_T : sel_j ? J_T : sel_z ? Z_T : pc + 32'd4;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Select bus must never be multi-hot
   always @(negedge clk)
      if (!reset)
         chk("sel_onehot", 32'($countones({sel_trap, sel_jr, sel_j, sel_z}) <= 1), 32'd1);

   // Apply inputs just after an edge, check the combinational outputs, then take the next edge
   task automatic step(input string tag, input logic [5:0] in, input logic [8:0] exp);
      {trap_req, br_taken, jr_req, j_req, load_use_stall, freeze} = in;
      #1;
      chk(tag, 32'(outs), 32'(exp));
      @(posedge clk);
      #1;
   endtask

   initial begin
      {trap_req, br_taken, jr_req, j_req, load_use_stall, freeze} = I_NONE;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      chk("epc_rst", epc, 32'h0);
      chk("pc0", pc, 32'h0);
      step("idle0", I_NONE, O_IDLE);
      chk("pc4", pc, 32'h4);
      step("idle1", I_NONE, O_IDLE);
      chk("pc8", pc, 32'h8);
      step("idle2", I_NONE, O_IDLE);

      step("br_and_j", I_BRJ, O_BR);
      chk("pc_br", pc, Z_T);

      step("jr_stall", I_JRLU, O_STALL);
      chk("pc_hold", pc, Z_T);
      step("jr_go", I_JR, O_JR);
      chk("pc_jr", pc, JR_T);
      step("j_go", I_J, O_J);
      chk("pc_j", pc, J_T);
      step("stall_only", I_LU, O_STALL);

      pc_ex = 32'h40;
      step("trap_acc", I_TRAP, O_TACC);
      chk("epc_40", epc, 32'h40);
      pc_ex = 32'h80;
      step("drain_trap2", I_TRAP, O_DRN);
      chk("epc_kept", epc, 32'h40);
      chk("pc_drain", pc, J_T);
      step("vector", I_NONE, O_VEC);
      chk("pc_vec", pc, TRAP_VECTOR);
      step("run_after", I_NONE, O_IDLE);
      chk("pc_68", pc, 32'h68);

      step("frz_br", I_FRZBR, O_FRZ);
      step("frz2", I_FRZ, O_FRZ);
      step("frz3", I_FRZ, O_FRZ);
      step("pend_br", I_NONE, O_BR);
      chk("pc_pend", pc, Z_T);
      step("pend_clr", I_NONE, O_IDLE);

      step("frz_j", I_FRZJ, O_FRZ);
      step("live_br_wins", I_BR, O_BR);
      step("pend_j_gone", I_NONE, O_IDLE);

      pc_ex = 32'h48;
      step("trap2_acc", I_TRAP, O_TACC);
      chk("epc_48", epc, 32'h48);
      step("drn_frz1", I_FRZ, O_FRZB);
      step("drn_frz2", I_FRZ, O_FRZB);
      step("drn_run", I_NONE, O_DRN);
      step("vec2", I_NONE, O_VEC);
      step("run2", I_NONE, O_IDLE);

      pc_ex = 32'h4c;
      step("trap3_acc", I_TRAP, O_TACC);
      {trap_req, br_taken, jr_req, j_req, load_use_stall, freeze} = I_NONE;
      #1 chk("mid_drain", 32'(outs), 32'(O_DRN));
      #1 reset = 1'b1;
      #1 chk("async_rst", 32'(outs), 32'(O_IDLE));
      chk("epc_rst2", epc, 32'h0);
      @(posedge clk);
      #1 reset = 1'b0;
      step("post_rst0", I_NONE, O_IDLE);
      step("post_rst1", I_NONE, O_IDLE);
      step("post_rst2", I_NONE, O_IDLE);
      chk("pc_post", pc, 32'hc);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
